// File: rtl/dual_regfile_sb_pkg.sv
// Shared types and constants for the dual-issue GPR file, HI/LO pair and
// in-flight-writer scoreboard.
package dual_regfile_sb_pkg;

    localparam int NREG_DEFAULT  = 32;
    localparam int CNT_W_DEFAULT = 2;
    localparam int NUM_READS     = 4;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  creg_addr_t;

    localparam creg_addr_t REG_ZERO = 5'd0;

    typedef struct packed {
        logic       valid;
        creg_addr_t dst;
        word_t      value;
    } write_reg_t;

    typedef struct packed {
        logic  hi_valid;
        logic  lo_valid;
        word_t hi;
        word_t lo;
    } write_hilo_t;

    // Number of the two slots that hit a given register this cycle (0..2).
    function automatic logic [1:0] hit_count(input logic slot_1_hit, input logic slot_2_hit);
        return {1'b0, slot_1_hit} + {1'b0, slot_2_hit};
    endfunction

endpackage

// File: rtl/dual_regfile_sb_if.sv
// Writeback, issue and read-port bundle between the pipeline (master) and
// the register file / scoreboard (slave).
interface dual_regfile_sb_if;
    import dual_regfile_sb_pkg::*;

    write_reg_t                      write_reg_1;
    write_reg_t                      write_reg_2;
    write_hilo_t                     write_hilo_1;
    write_hilo_t                     write_hilo_2;
    logic                            issue_valid_1;
    logic                            issue_valid_2;
    creg_addr_t                      issue_dst_1;
    creg_addr_t                      issue_dst_2;
    logic                            flush;
    // Read port order: index 0 = rs1, 1 = rt1, 2 = rs2, 3 = rt2.
    logic [NUM_READS-1:0][4:0]       raddr;
    logic [NUM_READS-1:0][31:0]      rdata;
    logic [NUM_READS-1:0]            rbusy;
    word_t                           hi;
    word_t                           lo;
    logic                            issue_ready;

    modport master (
        output write_reg_1, write_reg_2, write_hilo_1, write_hilo_2,
        output issue_valid_1, issue_valid_2, issue_dst_1, issue_dst_2,
        output flush, raddr,
        input  rdata, rbusy, hi, lo, issue_ready
    );

    modport slave (
        input  write_reg_1, write_reg_2, write_hilo_1, write_hilo_2,
        input  issue_valid_1, issue_valid_2, issue_dst_1, issue_dst_2,
        input  flush, raddr,
        output rdata, rbusy, hi, lo, issue_ready
    );

endinterface

// File: rtl/dual_regfile_sb_counter.sv
// Per-register in-flight writer counter: adds 0..2 issues, subtracts 0..2
// commits, clamps to [0, max] and clears on flush.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [1:0]       inc,
    input  logic [1:0]       dec,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic             would_overflow
);

    localparam int SUM_W = CNT_W + 2;
    localparam logic [SUM_W-1:0] MAX_CNT = SUM_W'((1 << CNT_W) - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] dec_ext;
    logic [SUM_W-1:0] net;

    // Issues are added before commits are removed so a same-cycle pair nets
    // out; the result is clamped on both ends rather than wrapping.
    always_comb begin
        sum     = {2'b00, count_q} + {{CNT_W{1'b0}}, inc};
        dec_ext = {{CNT_W{1'b0}}, dec};
        net     = sum - dec_ext;
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (sum <= dec_ext) begin
            count_d = '0;
        end else if (net > MAX_CNT) begin
            count_d = MAX_CNT[CNT_W-1:0];
        end else begin
            count_d = net[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count          = count_q;
    assign would_overflow = (sum > MAX_CNT);

endmodule

// File: rtl/dual_regfile_sb.sv
// Architectural GPR file, HI/LO pair and in-flight-writer scoreboard.
// Optional same-cycle write forwarding is enabled by defining REGFILE_BYPASS_EN.
module dual_regfile_sb
    import dual_regfile_sb_pkg::*;
#(
    parameter int NREG  = NREG_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              resetn,
    dual_regfile_sb_if.slave  bus
);

    logic commit_1;
    logic commit_2;

    word_t regs_q [NREG];
    word_t regs_d [NREG];
    word_t hi_q;
    word_t hi_d;
    word_t lo_q;
    word_t lo_d;

    logic [1:0]       inc_cnt [NREG];
    logic [1:0]       dec_cnt [NREG];
    logic [CNT_W-1:0] cnt     [NREG];
    logic [NREG-1:0]  ovf;

    assign commit_1 = bus.write_reg_1.valid && (bus.write_reg_1.dst != REG_ZERO);
    assign commit_2 = bus.write_reg_2.valid && (bus.write_reg_2.dst != REG_ZERO);

    // Slot 2 is younger, so its write is applied last and wins on collision.
    always_comb begin
        regs_d = regs_q;
        if (commit_1) begin
            regs_d[bus.write_reg_1.dst] = bus.write_reg_1.value;
        end
        if (commit_2) begin
            regs_d[bus.write_reg_2.dst] = bus.write_reg_2.value;
        end
        regs_d[0] = '0;
    end

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (bus.write_hilo_1.hi_valid) hi_d = bus.write_hilo_1.hi;
        if (bus.write_hilo_2.hi_valid) hi_d = bus.write_hilo_2.hi;
        if (bus.write_hilo_1.lo_valid) lo_d = bus.write_hilo_1.lo;
        if (bus.write_hilo_2.lo_valid) lo_d = bus.write_hilo_2.lo;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            regs_q <= regs_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    // r0 gets a counter too, but its increments and decrements are masked so it stays at zero.
    for (genvar r = 0; r < NREG; r++) begin : g_sb
        assign inc_cnt[r] = hit_count(
            (r != 0) && bus.issue_valid_1 && (bus.issue_dst_1 == creg_addr_t'(r)),
            (r != 0) && bus.issue_valid_2 && (bus.issue_dst_2 == creg_addr_t'(r)));
        assign dec_cnt[r] = hit_count(
            commit_1 && (bus.write_reg_1.dst == creg_addr_t'(r)),
            commit_2 && (bus.write_reg_2.dst == creg_addr_t'(r)));

        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk            (clk),
            .resetn         (resetn),
            .inc            (inc_cnt[r]),
            .dec            (dec_cnt[r]),
            .flush          (bus.flush),
            .count          (cnt[r]),
            .would_overflow (ovf[r])
        );
    end

    assign bus.issue_ready = ~|ovf;

    always_comb begin
        bus.rdata = '0;
        bus.rbusy = '0;
        for (int i = 0; i < NUM_READS; i++) begin
            bus.rdata[i] = regs_q[bus.raddr[i]];
            bus.rbusy[i] = (cnt[bus.raddr[i]] != '0);
`ifdef REGFILE_BYPASS_EN
            if (commit_2 && (bus.write_reg_2.dst == bus.raddr[i])) begin
                bus.rdata[i] = bus.write_reg_2.value;
            end else if (commit_1 && (bus.write_reg_1.dst == bus.raddr[i])) begin
                bus.rdata[i] = bus.write_reg_1.value;
            end
            if ((dec_cnt[bus.raddr[i]] != 2'd0) &&
                (({2'b00, cnt[bus.raddr[i]]} + {{CNT_W{1'b0}}, inc_cnt[bus.raddr[i]]}) <=
                 {{CNT_W{1'b0}}, dec_cnt[bus.raddr[i]]})) begin
                bus.rbusy[i] = 1'b0;
            end
`endif
            if (bus.raddr[i] == REG_ZERO) begin
                bus.rdata[i] = '0;
                bus.rbusy[i] = 1'b0;
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign bus.hi = hi_d;
    assign bus.lo = lo_d;
`else
    assign bus.hi = hi_q;
    assign bus.lo = lo_q;
`endif

endmodule

// File: tb/tb_dual_regfile_sb.sv
// Directed self-checking bench for dual_regfile_sb.
module tb_dual_regfile_sb;
    import dual_regfile_sb_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    int   errors = 0;
    int   checks = 0;

    dual_regfile_sb_if bus();

    dual_regfile_sb #(.NREG(32), .CNT_W(2)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic clearInputs();
        bus.write_reg_1   = '0;
        bus.write_reg_2   = '0;
        bus.write_hilo_1  = '0;
        bus.write_hilo_2  = '0;
        bus.issue_valid_1 = 1'b0;
        bus.issue_valid_2 = 1'b0;
        bus.issue_dst_1   = '0;
        bus.issue_dst_2   = '0;
        bus.flush         = 1'b0;
        bus.raddr         = '0;
    endtask

    // Clock the current inputs in through one edge, then return to idle.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        clearInputs();
        #1;
    endtask

    task automatic issue(input logic v1, input creg_addr_t d1, input logic v2, input creg_addr_t d2);
        bus.issue_valid_1 = v1;
        bus.issue_dst_1   = d1;
        bus.issue_valid_2 = v2;
        bus.issue_dst_2   = d2;
    endtask

    initial begin
        clearInputs();
        resetn = 1'b0;
        #1;
        for (int i = 0; i < NUM_READS; i++) begin
            checkOutput("reset_rdata", bus.rdata[i], 32'h0);
        end
        checkOutput("reset_rbusy", {28'h0, bus.rbusy}, 32'h0);
        checkOutput("reset_hi", bus.hi, 32'h0);
        checkOutput("reset_lo", bus.lo, 32'h0);
        checkOutput("reset_ready", {31'h0, bus.issue_ready}, 32'h1);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #2;

        $display("[TB] dual write collision");
        bus.write_reg_1 = '{valid: 1'b1, dst: 5'd5, value: 32'hAAAA};
        bus.write_reg_2 = '{valid: 1'b1, dst: 5'd5, value: 32'hBBBB};
        bus.raddr[0]    = 5'd5;
        #1;
        checkOutput("collision_same_cycle", bus.rdata[0], BYPASS ? 32'hBBBB : 32'h0);
        applyStimulus();
        bus.raddr[0] = 5'd5;
        #1;
        checkOutput("collision_r5", bus.rdata[0], 32'hBBBB);

        $display("[TB] r0 protection");
        bus.write_reg_1 = '{valid: 1'b1, dst: 5'd0, value: 32'h1234};
        issue(1'b1, 5'd0, 1'b1, 5'd0);
        applyStimulus();
        bus.raddr[0] = 5'd0;
        bus.raddr[1] = 5'd5;
        #1;
        checkOutput("r0_rdata", bus.rdata[0], 32'h0);
        checkOutput("r0_rbusy", {31'h0, bus.rbusy[0]}, 32'h0);
        checkOutput("r5_kept", bus.rdata[1], 32'hBBBB);

        $display("[TB] scoreboard r7");
        issue(1'b1, 5'd7, 1'b1, 5'd7);
        applyStimulus();
        bus.raddr[1] = 5'd7;
        #1;
        checkOutput("r7_busy_cnt2", {31'h0, bus.rbusy[1]}, 32'h1);
        issue(1'b1, 5'd7, 1'b1, 5'd7);
        #1;
        checkOutput("r7_cnt2_plus2_ready", {31'h0, bus.issue_ready}, 32'h0);
        issue(1'b1, 5'd7, 1'b0, 5'd0);
        #1;
        checkOutput("r7_cnt2_plus1_ready", {31'h0, bus.issue_ready}, 32'h1);
        issue(1'b0, 5'd0, 1'b0, 5'd0);
        bus.write_reg_1 = '{valid: 1'b1, dst: 5'd7, value: 32'h70};
        applyStimulus();
        bus.raddr[1] = 5'd7;
        #1;
        checkOutput("r7_busy_cnt1", {31'h0, bus.rbusy[1]}, 32'h1);
        issue(1'b1, 5'd7, 1'b1, 5'd7);
        #1;
        checkOutput("r7_cnt1_plus2_ready", {31'h0, bus.issue_ready}, 32'h1);
        issue(1'b0, 5'd0, 1'b0, 5'd0);
        bus.write_reg_2 = '{valid: 1'b1, dst: 5'd7, value: 32'h71};
        applyStimulus();
        bus.raddr[1] = 5'd7;
        #1;
        checkOutput("r7_busy_cnt0", {31'h0, bus.rbusy[1]}, 32'h0);
        checkOutput("r7_value", bus.rdata[1], 32'h71);

        $display("[TB] decrement saturates at zero");
        bus.write_reg_1 = '{valid: 1'b1, dst: 5'd10, value: 32'hA};
        applyStimulus();
        bus.raddr[2] = 5'd10;
        issue(1'b1, 5'd10, 1'b1, 5'd10);
        #1;
        checkOutput("r10_busy_after_commit", {31'h0, bus.rbusy[2]}, 32'h0);
        checkOutput("r10_ready_plus2", {31'h0, bus.issue_ready}, 32'h1);
        issue(1'b0, 5'd0, 1'b0, 5'd0);

        $display("[TB] issue and commit net out");
        issue(1'b1, 5'd11, 1'b1, 5'd11);
        bus.write_reg_1 = '{valid: 1'b1, dst: 5'd11, value: 32'hB};
        applyStimulus();
        bus.raddr[2] = 5'd11;
        issue(1'b1, 5'd11, 1'b1, 5'd11);
        #1;
        checkOutput("r11_busy_cnt1", {31'h0, bus.rbusy[2]}, 32'h1);
        checkOutput("r11_ready_plus2", {31'h0, bus.issue_ready}, 32'h1);
        issue(1'b0, 5'd0, 1'b0, 5'd0);
        bus.write_reg_1 = '{valid: 1'b1, dst: 5'd11, value: 32'hC};
        applyStimulus();

        $display("[TB] overflow on r3");
        issue(1'b1, 5'd3, 1'b1, 5'd3);
        applyStimulus();
        issue(1'b1, 5'd3, 1'b0, 5'd0);
        applyStimulus();
        bus.raddr[3] = 5'd3;
        issue(1'b1, 5'd3, 1'b0, 5'd0);
        #1;
        checkOutput("r3_busy_cnt3", {31'h0, bus.rbusy[3]}, 32'h1);
        checkOutput("r3_overflow_ready", {31'h0, bus.issue_ready}, 32'h0);
        issue(1'b0, 5'd0, 1'b1, 5'd4);
        #1;
        checkOutput("r4_ready_with_r3_full", {31'h0, bus.issue_ready}, 32'h1);
        issue(1'b0, 5'd0, 1'b0, 5'd0);

        $display("[TB] flush with commit");
        bus.flush       = 1'b1;
        bus.write_reg_1 = '{valid: 1'b1, dst: 5'd9, value: 32'h55};
        issue(1'b1, 5'd9, 1'b0, 5'd0);
        applyStimulus();
        bus.raddr[0] = 5'd9;
        bus.raddr[3] = 5'd3;
        issue(1'b1, 5'd3, 1'b1, 5'd3);
        #1;
        checkOutput("flush_r9_value", bus.rdata[0], 32'h55);
        checkOutput("flush_r9_busy", {31'h0, bus.rbusy[0]}, 32'h0);
        checkOutput("flush_r3_busy", {31'h0, bus.rbusy[3]}, 32'h0);
        checkOutput("flush_r3_ready_plus2", {31'h0, bus.issue_ready}, 32'h1);
        issue(1'b0, 5'd0, 1'b0, 5'd0);

        $display("[TB] HI/LO");
        bus.write_hilo_1 = '{hi_valid: 1'b1, lo_valid: 1'b0, hi: 32'h1, lo: 32'hDEAD};
        bus.write_hilo_2 = '{hi_valid: 1'b0, lo_valid: 1'b1, hi: 32'hBEEF, lo: 32'h2};
        #1;
        checkOutput("hilo_hi_same_cycle", bus.hi, BYPASS ? 32'h1 : 32'h0);
        checkOutput("hilo_lo_same_cycle", bus.lo, BYPASS ? 32'h2 : 32'h0);
        applyStimulus();
        checkOutput("hilo_hi", bus.hi, 32'h1);
        checkOutput("hilo_lo", bus.lo, 32'h2);
        bus.write_hilo_1 = '{hi_valid: 1'b1, lo_valid: 1'b1, hi: 32'h11, lo: 32'h33};
        bus.write_hilo_2 = '{hi_valid: 1'b1, lo_valid: 1'b1, hi: 32'h22, lo: 32'h44};
        applyStimulus();
        checkOutput("hilo_collision_hi", bus.hi, 32'h22);
        checkOutput("hilo_collision_lo", bus.lo, 32'h44);

        $display("[TB] reset mid-run");
        issue(1'b1, 5'd12, 1'b0, 5'd0);
        applyStimulus();
        bus.raddr[0] = 5'd5;
        bus.raddr[1] = 5'd12;
        #1;
        checkOutput("pre_reset_r12_busy", {31'h0, bus.rbusy[1]}, 32'h1);
        resetn = 1'b0;
        #1;
        checkOutput("midreset_r5", bus.rdata[0], 32'h0);
        checkOutput("midreset_r12_busy", {31'h0, bus.rbusy[1]}, 32'h0);
        checkOutput("midreset_hi", bus.hi, 32'h0);
        checkOutput("midreset_lo", bus.lo, 32'h0);
        checkOutput("midreset_ready", {31'h0, bus.issue_ready}, 32'h1);
        bus.write_reg_1 = '{valid: 1'b1, dst: 5'd5, value: 32'h99};
        applyStimulus();
        @(negedge clk);
        resetn = 1'b1;
        bus.raddr[0] = 5'd5;
        #1;
        checkOutput("postreset_r5", bus.rdata[0], 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
